// File: rtl/bus_pkg.sv
// bus_pkg: shared types for the shared-memory bus controller.
//   - state_t    : controller FSM states (IDLE / ACCESS / DONE)
//   - BUS_ADDR_W : default memory tag width
//   - BUS_DATA_W : default data word width
//   - cmd_t      : latched command {we, tag, wdata}
//   - idx_width  : bits needed to index n items (at least 1)
package bus_pkg;

   localparam int BUS_ADDR_W = 3;
   localparam int BUS_DATA_W = 16;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_t;

   // Field widths follow the package defaults; a top that overrides
   // ADDR_W/DATA_W must be paired with matching package widths.
   typedef struct packed {
      logic                  we;
      logic [BUS_ADDR_W-1:0] tag;
      logic [BUS_DATA_W-1:0] wdata;
   } cmd_t;

   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick.
//   req        in  N_REQ  request vector
//   last_grant in  IDX_W  index of the most recent winner
//   winner     out N_REQ  one-hot winner (all zero when req is zero)
// The search starts at last_grant+1 and wraps, so the previous winner
// has the lowest priority.
module rr_arbiter
   import bus_pkg::*;
#(
   parameter  int N_REQ = 3,
   localparam int IDX_W = idx_width(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IDX_W-1:0] last_grant,
   output logic [N_REQ-1:0] winner
);

   logic             found;
   logic [IDX_W-1:0] pos;

   always_comb begin
      winner = '0;
      found  = 1'b0;
      pos    = '0;
      for (int k = 1; k <= N_REQ; k++) begin
         pos = IDX_W'((int'(last_grant) + k) % N_REQ);
         if (!found && req[pos]) begin
            winner[pos] = 1'b1;
            found       = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: round-robin controller for a single shared memory.
//   clk, reset   : clock and asynchronous active-high reset
//   req/we       : per-requester request and write-back(1)/read(0) select
//   tag/wdata    : per-requester tag and write data, requester i at
//                  [i*W +: W]
//   gnt          : registered one-hot grant, held through ACCESS and DONE
//   done         : one-cycle completion pulse
//   rdata        : last read result, held until the next read completes
//   mem_*        : memory pins; enables are only high during ACCESS
//   mem_data_out : memory read data, sampled on the last ACCESS cycle
module mem_bus_arbiter
   import bus_pkg::*;
#(
   parameter int N_REQ   = 3,
   parameter int ADDR_W  = BUS_ADDR_W,
   parameter int DATA_W  = BUS_DATA_W,
   parameter int MEM_LAT = 2
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [N_REQ-1:0]         req,
   input  logic [N_REQ-1:0]         we,
   input  logic [N_REQ*ADDR_W-1:0]  tag,
   input  logic [N_REQ*DATA_W-1:0]  wdata,
   output logic [N_REQ-1:0]         gnt,
   output logic                     done,
   output logic [DATA_W-1:0]        rdata,
   output logic                     mem_enable,
   output logic                     mem_w_enable,
   output logic [ADDR_W-1:0]        mem_tag,
   output logic [DATA_W-1:0]        mem_data_in,
   input  logic [DATA_W-1:0]        mem_data_out
);

   localparam int IDX_W = idx_width(N_REQ);
   localparam int CNT_W = idx_width(MEM_LAT);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT - 1);

   state_t             state, state_nx;
   logic [IDX_W-1:0]   last_grant;
   logic [N_REQ-1:0]   winner;
   logic [IDX_W-1:0]   win_idx;
   logic [CNT_W-1:0]   cnt, cnt_nx;
   cmd_t               cmd, cmd_nx;
   logic [N_REQ-1:0]   gnt_nx;
   logic               done_nx, men_nx, mwen_nx;
   logic               grant_now, cap_rd, lg_upd;
   logic [ADDR_W-1:0]  tag_arr   [N_REQ];
   logic [DATA_W-1:0]  wdata_arr [N_REQ];

   function automatic logic [IDX_W-1:0] oh_to_idx(input logic [N_REQ-1:0] oh);
      oh_to_idx = '0;
      for (int k = 0; k < N_REQ; k++) begin
         if (oh[k]) oh_to_idx = IDX_W'(k);
      end
   endfunction

   for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
      assign tag_arr[g]   = tag[g*ADDR_W +: ADDR_W];
      assign wdata_arr[g] = wdata[g*DATA_W +: DATA_W];
   end

   rr_arbiter #(.N_REQ(N_REQ)) u_rr_arbiter (
      .req        (req),
      .last_grant (last_grant),
      .winner     (winner)
   );

   assign win_idx = oh_to_idx(winner);

   // State and output registers; every output pin comes from here.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= IDLE;
         last_grant   <= IDX_W'(N_REQ - 1);
         cnt          <= '0;
         cmd          <= '0;
         gnt          <= '0;
         done         <= 1'b0;
         mem_enable   <= 1'b0;
         mem_w_enable <= 1'b0;
         rdata        <= '0;
      end else begin
         state        <= state_nx;
         cnt          <= cnt_nx;
         cmd          <= cmd_nx;
         gnt          <= gnt_nx;
         done         <= done_nx;
         mem_enable   <= men_nx;
         mem_w_enable <= mwen_nx;
         if (lg_upd) last_grant <= oh_to_idx(gnt);
         if (cap_rd) rdata      <= mem_data_out;
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (|req)      state_nx = ACCESS;
         ACCESS:  if (cnt == '0) state_nx = DONE;
         DONE:                   state_nx = IDLE;
         default:                state_nx = IDLE;
      endcase
   end

   // Next values for the registered outputs. The write enable is derived
   // from the command being latched so it is stable for the whole window.
   always_comb begin
      grant_now = (state == IDLE) && (state_nx == ACCESS);
      cmd_nx    = cmd;
      cnt_nx    = cnt;
      gnt_nx    = gnt;
      if (grant_now) begin
         cmd_nx.we    = we[win_idx];
         cmd_nx.tag   = tag_arr[win_idx];
         cmd_nx.wdata = wdata_arr[win_idx];
         cnt_nx       = CNT_LOAD;
         gnt_nx       = winner;
      end else if ((state == ACCESS) && (cnt != '0)) begin
         cnt_nx = cnt - 1'b1;
      end
      if (state_nx == IDLE) gnt_nx = '0;
      done_nx = (state_nx == DONE);
      men_nx  = (state_nx == ACCESS);
      mwen_nx = men_nx && cmd_nx.we;
      cap_rd  = (state == ACCESS) && (cnt == '0) && !cmd.we;
      lg_upd  = (state == DONE);
   end

   assign mem_tag     = cmd.tag;
   assign mem_data_in = cmd.wdata;

endmodule
